alarm_arm_ctrl: RTL and testbench
=================================

Name: alarm_arm_ctrl

Overview:
Sequential arming controller that drives the alarm detector's alarm_set/alarm_stay inputs and consumes its secure/alarm outputs. Handles keypad arm and disarm requests, exit and entry delays, siren timing, and bad-code lockout. Sits between the keypad front end and the combinational alarm detector.

Parameters:
EXIT_CYCLES, 8, length of exit delay in clk cycles (>=1)
ENTRY_CYCLES, 8, length of entry delay in clk cycles (>=1)
SIREN_CYCLES, 16, siren on-time in clk cycles before auto re-arm (>=1)
CNT_W, 8, delay counter width; must hold max(EXIT,ENTRY,SIREN)-1
MAX_BAD, 3, consecutive bad codes that force siren (1..3)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
arm_away  input  1  one-cycle request: arm in away mode
arm_stay  input  1  one-cycle request: arm in stay mode
disarm  input  1  one-cycle disarm request
code_ok  input  1  keypad code valid; sampled only with disarm
secure  input  1  detector secure output (all doors/windows closed)
sensor_alarm  input  1  detector alarm output
alarm_set  output  1  to detector: system armed
alarm_stay  output  1  to detector: stay mode (perimeter only)
siren  output  1  siren drive
exit_active  output  1  exit delay running
entry_active  output  1  entry delay running
arm_fail  output  1  one-cycle pulse: arm refused, not secure
bad_code  output  1  one-cycle pulse: disarm with code_ok=0

Behaviour:
- Single clock domain; all state updates on posedge clk; rst_n asynchronous active-low clears all flops immediately.
- Reset: state=DISARMED, mode=0, counter=0, bad_cnt=0; every output 0.
- States: DISARMED, EXIT_DELAY, ARMED, ENTRY_DELAY, SIREN. Level outputs are Moore decodes of the state/mode registers. arm_fail and bad_code are registered pulses, asserted the cycle after the causing input.
- alarm_set = 1 in ARMED, ENTRY_DELAY, SIREN. It is 0 in DISARMED and EXIT_DELAY, so the detector cannot trip while the occupant leaves.
- alarm_stay = mode while alarm_set=1; otherwise 0.
- siren = 1 only in SIREN. exit_active = EXIT_DELAY. entry_active = ENTRY_DELAY.
- DISARMED transitions:
  - arm_stay with secure=1: ARMED, mode=1, no exit delay.
  - arm_away with secure=1: EXIT_DELAY, mode=0.
  - Either arm request with secure=0: stay in DISARMED, pulse arm_fail.
  - arm_stay and arm_away together: treated as arm_stay.
  - disarm is ignored; no bad_code pulse.
- Timed states (EXIT_DELAY, ENTRY_DELAY, SIREN): the counter loads N-1 on entry and decrements each cycle. The exit edge is taken when counter==0, so the state lasts exactly N cycles.
  - EXIT_DELAY expiry: ARMED.
  - ENTRY_DELAY expiry: SIREN.
  - SIREN expiry: ARMED with the same mode. If sensor_alarm is still 1, the ARMED rules below then apply on the next edge.
- ARMED with sensor_alarm=1:
  - mode=0: ENTRY_DELAY.
  - mode=1: SIREN directly.
- ENTRY_DELAY ignores sensor_alarm; the delay is not restarted.
- Disarm, any state other than DISARMED, highest priority over timers and sensor:
  - disarm & code_ok: DISARMED, bad_cnt=0, counter=0.
  - disarm & !code_ok: bad_code pulse; bad_cnt increments, saturating at MAX_BAD.
  - When bad_cnt reaches MAX_BAD: enter SIREN from EXIT_DELAY, ARMED or ENTRY_DELAY, with alarm_set forced via the SIREN state.
  - In SIREN, further bad codes only pulse bad_code; the siren timer does not restart.
- Arm requests outside DISARMED are ignored; no arm_fail.
- bad_cnt clears only on a good disarm or on reset. It persists across SIREN-to-ARMED re-arm.
- A good disarm and timer expiry in the same cycle: the disarm wins.
- Reset asserted mid-delay or mid-siren: immediately DISARMED with all outputs 0; the counter does not resume after release.

Test Plan:
- Reset then arm_away with secure=1 → exit_active=1 for exactly 8 cycles, alarm_set=0; alarm_set=1, alarm_stay=0 on the 9th cycle.
- Arm_away with secure=0 → arm_fail high 1 cycle; state stays DISARMED; alarm_set=0.
- Armed away, sensor_alarm=1 → entry_active for 8 cycles, then siren=1 for 16 cycles. Return to ARMED (alarm_set=1, siren=0); a good disarm at entry cycle 5 instead gives all outputs 0 next cycle.
- Arm_stay with secure=1 → alarm_set=1, alarm_stay=1 next cycle; sensor_alarm=1 → siren=1 next cycle, no entry delay.
- Armed, three disarm pulses with code_ok=0 → bad_code pulses ×3; siren=1 after the third. A good disarm then clears everything, and a subsequent single bad code does not trigger the siren.
- rst_n low at exit cycle 4 → outputs 0 asynchronously; after release, no transition to ARMED occurs without a new arm request.

Source files
------------

// File: rtl/alarm_arm_ctrl.sv
// Arming controller for the alarm detector: exit/entry delays, siren timing
// with automatic re-arm, and bad-code lockout. Level outputs decode state/mode.
module alarm_arm_ctrl #(
  parameter int EXIT_CYCLES  = 8,
  parameter int ENTRY_CYCLES = 8,
  parameter int SIREN_CYCLES = 16,
  parameter int CNT_W        = 8,
  parameter int MAX_BAD      = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic arm_away,
  input  logic arm_stay,
  input  logic disarm,
  input  logic code_ok,
  input  logic secure,
  input  logic sensor_alarm,
  output logic alarm_set,
  output logic alarm_stay,
  output logic siren,
  output logic exit_active,
  output logic entry_active,
  output logic arm_fail,
  output logic bad_code
);

  typedef enum logic [2:0] {
    S_DISARMED,
    S_EXIT_DELAY,
    S_ARMED,
    S_ENTRY_DELAY,
    S_SIREN
  } state_t;

  localparam logic [CNT_W-1:0] EXIT_LOAD  = CNT_W'(EXIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] ENTRY_LOAD = CNT_W'(ENTRY_CYCLES - 1);
  localparam logic [CNT_W-1:0] SIREN_LOAD = CNT_W'(SIREN_CYCLES - 1);
  localparam logic [1:0]       BAD_LIMIT  = 2'(MAX_BAD);

  state_t           state_reg, state_next;
  logic             mode_reg, mode_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [1:0]       bad_cnt_reg, bad_cnt_next;
  logic             arm_fail_reg, arm_fail_next;
  logic             bad_code_reg, bad_code_next;

  logic             timer_done;
  logic             good_disarm;
  logic             bad_attempt;
  logic [1:0]       bad_cnt_inc;
  logic             lockout;
  logic             arm_req;

  assign timer_done  = (cnt_reg == '0);
  assign good_disarm = disarm && code_ok;
  assign bad_attempt = disarm && !code_ok;
  assign arm_req     = arm_away || arm_stay;
  assign bad_cnt_inc = (bad_cnt_reg >= BAD_LIMIT) ? BAD_LIMIT : bad_cnt_reg + 2'd1;
  // A bad code that reaches the limit forces the siren, except when already sounding.
  assign lockout     = bad_attempt && (bad_cnt_inc == BAD_LIMIT) && (state_reg != S_SIREN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= S_DISARMED;
      mode_reg     <= 1'b0;
      cnt_reg      <= '0;
      bad_cnt_reg  <= 2'd0;
      arm_fail_reg <= 1'b0;
      bad_code_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      mode_reg     <= mode_next;
      cnt_reg      <= cnt_next;
      bad_cnt_reg  <= bad_cnt_next;
      arm_fail_reg <= arm_fail_next;
      bad_code_reg <= bad_code_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    mode_next     = mode_reg;
    cnt_next      = cnt_reg;
    bad_cnt_next  = bad_cnt_reg;
    arm_fail_next = 1'b0;
    bad_code_next = 1'b0;

    if (state_reg == S_DISARMED) begin
      if (arm_req) begin
        if (!secure) begin
          arm_fail_next = 1'b1;
        end else if (arm_stay) begin
          state_next = S_ARMED;
          mode_next  = 1'b1;
          cnt_next   = '0;
        end else begin
          state_next = S_EXIT_DELAY;
          mode_next  = 1'b0;
          cnt_next   = EXIT_LOAD;
        end
      end
    end else if (good_disarm) begin
      // A valid code overrides timers and sensors in every armed state.
      state_next   = S_DISARMED;
      mode_next    = 1'b0;
      cnt_next     = '0;
      bad_cnt_next = 2'd0;
    end else begin
      if (bad_attempt) begin
        bad_code_next = 1'b1;
        bad_cnt_next  = bad_cnt_inc;
      end

      if (lockout) begin
        state_next = S_SIREN;
        cnt_next   = SIREN_LOAD;
      end else begin
        case (state_reg)
          S_EXIT_DELAY: begin
            if (timer_done) begin
              state_next = S_ARMED;
            end else begin
              cnt_next = cnt_reg - 1'b1;
            end
          end
          S_ARMED: begin
            if (sensor_alarm) begin
              if (mode_reg) begin
                state_next = S_SIREN;
                cnt_next   = SIREN_LOAD;
              end else begin
                state_next = S_ENTRY_DELAY;
                cnt_next   = ENTRY_LOAD;
              end
            end
          end
          S_ENTRY_DELAY: begin
            if (timer_done) begin
              state_next = S_SIREN;
              cnt_next   = SIREN_LOAD;
            end else begin
              cnt_next = cnt_reg - 1'b1;
            end
          end
          S_SIREN: begin
            // Re-arm in the same mode; counter is already zero here.
            if (timer_done) begin
              state_next = S_ARMED;
            end else begin
              cnt_next = cnt_reg - 1'b1;
            end
          end
          default: begin
            state_next = S_DISARMED;
            mode_next  = 1'b0;
            cnt_next   = '0;
          end
        endcase
      end
    end
  end

  assign alarm_set    = (state_reg == S_ARMED) || (state_reg == S_ENTRY_DELAY) ||
                        (state_reg == S_SIREN);
  assign alarm_stay   = alarm_set && mode_reg;
  assign siren        = (state_reg == S_SIREN);
  assign exit_active  = (state_reg == S_EXIT_DELAY);
  assign entry_active = (state_reg == S_ENTRY_DELAY);
  assign arm_fail     = arm_fail_reg;
  assign bad_code     = bad_code_reg;

endmodule

// File: tb/tb_alarm_arm_ctrl.sv
// Scoreboard bench for alarm_arm_ctrl: directed scenarios then random traffic,
// expected outputs from a deadline-based reference model.
module tb_alarm_arm_ctrl;

  localparam int EXIT_N  = 8;
  localparam int ENTRY_N = 8;
  localparam int SIREN_N = 16;
  localparam int MAXB    = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic arm_away = 1'b0, arm_stay = 1'b0, disarm = 1'b0, code_ok = 1'b0;
  logic secure = 1'b0, sensor_alarm = 1'b0;
  logic alarm_set, alarm_stay, siren, exit_active, entry_active, arm_fail, bad_code;
  logic [6:0] dut_v;

  always #5 clk = ~clk;

  alarm_arm_ctrl #(
    .EXIT_CYCLES(EXIT_N), .ENTRY_CYCLES(ENTRY_N), .SIREN_CYCLES(SIREN_N),
    .CNT_W(8), .MAX_BAD(MAXB)
  ) dut (
    .clk(clk), .rst_n(rst_n), .arm_away(arm_away), .arm_stay(arm_stay),
    .disarm(disarm), .code_ok(code_ok), .secure(secure), .sensor_alarm(sensor_alarm),
    .alarm_set(alarm_set), .alarm_stay(alarm_stay), .siren(siren),
    .exit_active(exit_active), .entry_active(entry_active),
    .arm_fail(arm_fail), .bad_code(bad_code)
  );

  assign dut_v = {alarm_set, alarm_stay, siren, exit_active, entry_active, arm_fail, bad_code};

  typedef struct {
    logic [6:0] v;
    int         edge_no;
  } exp_t;

  exp_t q[$];
  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: phase plus absolute edge number at which a timed phase ends.
  localparam int P_OFF = 0, P_LEAVE = 1, P_WATCH = 2, P_ENTRY = 3, P_SIREN = 4;
  int   m_ph = P_OFF, m_mode = 0, m_bad = 0, m_deadline = 0, m_edge = 0;
  logic m_fail = 1'b0, m_badp = 1'b0;

  function automatic logic [6:0] m_outs();
    logic armed;
    armed = (m_ph == P_WATCH) || (m_ph == P_ENTRY) || (m_ph == P_SIREN);
    return {armed, armed && (m_mode == 1), m_ph == P_SIREN, m_ph == P_LEAVE,
            m_ph == P_ENTRY, m_fail, m_badp};
  endfunction

  task automatic model_edge(input logic r, input logic aa, input logic as_,
                            input logic dis, input logic ok, input logic sec,
                            input logic sens);
    bit forced;
    forced = 1'b0;
    m_fail = 1'b0;
    m_badp = 1'b0;
    if (!r) begin
      m_ph = P_OFF; m_mode = 0; m_bad = 0;
    end else if (m_ph == P_OFF) begin
      if (aa || as_) begin
        if (!sec) m_fail = 1'b1;
        else if (as_) begin m_ph = P_WATCH; m_mode = 1; end
        else begin m_ph = P_LEAVE; m_mode = 0; m_deadline = m_edge + EXIT_N; end
      end
    end else if (dis && ok) begin
      m_ph = P_OFF; m_mode = 0; m_bad = 0;
    end else begin
      if (dis) begin
        m_badp = 1'b1;
        if (m_bad < MAXB) m_bad++;
        forced = (m_bad == MAXB) && (m_ph != P_SIREN);
      end
      if (forced) begin
        m_ph = P_SIREN; m_deadline = m_edge + SIREN_N;
      end else begin
        case (m_ph)
          P_LEAVE: if (m_edge == m_deadline) m_ph = P_WATCH;
          P_WATCH: if (sens) begin
            if (m_mode == 1) begin m_ph = P_SIREN; m_deadline = m_edge + SIREN_N; end
            else begin m_ph = P_ENTRY; m_deadline = m_edge + ENTRY_N; end
          end
          P_ENTRY: if (m_edge == m_deadline) begin
            m_ph = P_SIREN; m_deadline = m_edge + SIREN_N;
          end
          P_SIREN: if (m_edge == m_deadline) m_ph = P_WATCH;
          default: ;
        endcase
      end
    end
    m_edge++;
  endtask

  task automatic check(input string name, input logic [6:0] got, input logic [6:0] want,
                       input int edge_no);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s edge=%0d got=%b want=%b (set,stay,siren,exit,entry,fail,bad)",
               name, edge_no, got, want);
    end
  endtask

  // One edge of stimulus; expected post-edge outputs go to the scoreboard.
  task automatic drive(input logic r, input logic aa, input logic as_, input logic dis,
                       input logic ok, input logic sec, input logic sens);
    exp_t e;
    @(negedge clk);
    rst_n = r; arm_away = aa; arm_stay = as_; disarm = dis; code_ok = ok;
    secure = sec; sensor_alarm = sens;
    if (!r) begin
      #1;
      check("async_reset", dut_v, 7'b0, m_edge);
    end
    model_edge(r, aa, as_, dis, ok, sec, sens);
    e.v = m_outs();
    e.edge_no = m_edge;
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  // Monitor: outputs are presented every cycle, sampled 1 time unit after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        $display("edge %0d dut=%b exp=%b", e.edge_no, dut_v, e.v);
        check("outputs", dut_v, e.v, e.edge_no);
      end
    end
  end

  initial begin
    logic r, aa, as_, dis, ok, sec, sens;
    int wait_cnt;

    // reset, then away arm with exit delay
    repeat (2) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1, 1, 0, 0, 0, 1, 0);
    idle(10);
    drive(1, 0, 0, 1, 1, 1, 0);
    // refused arm, simultaneous arm requests, disarm while disarmed
    drive(1, 1, 0, 0, 0, 0, 0);
    idle(2);
    drive(1, 0, 0, 1, 0, 1, 0);
    drive(1, 1, 1, 0, 0, 1, 0);
    drive(1, 0, 0, 1, 1, 1, 0);
    // away: entry delay, siren, re-arm; then good disarm mid entry
    drive(1, 1, 0, 0, 0, 1, 0);
    idle(9);
    drive(1, 0, 0, 0, 0, 1, 1);
    idle(30);
    drive(1, 0, 0, 0, 0, 1, 1);
    idle(4);
    drive(1, 0, 0, 1, 1, 1, 0);
    idle(2);
    // stay: immediate siren
    drive(1, 0, 1, 0, 0, 1, 0);
    drive(1, 0, 0, 0, 0, 1, 1);
    idle(3);
    drive(1, 0, 0, 1, 1, 1, 0);
    // bad-code lockout, clear, single bad code afterwards
    drive(1, 0, 1, 0, 0, 1, 0);
    repeat (3) begin
      drive(1, 0, 0, 1, 0, 1, 0);
      idle(1);
    end
    idle(2);
    drive(1, 0, 0, 1, 1, 1, 0);
    drive(1, 0, 1, 0, 0, 1, 0);
    drive(1, 0, 0, 1, 0, 1, 0);
    idle(3);
    drive(1, 0, 0, 1, 1, 1, 0);
    // good disarm on the exit-expiry edge
    drive(1, 1, 0, 0, 0, 1, 0);
    idle(7);
    drive(1, 0, 0, 1, 1, 1, 0);
    idle(2);
    // reset mid exit delay, no resumption afterwards
    drive(1, 1, 0, 0, 0, 1, 0);
    idle(3);
    repeat (2) drive(0, 0, 0, 0, 0, 1, 0);
    idle(12);

    for (int i = 0; i < 4000; i++) begin
      r    = ($urandom_range(999) >= 3);
      aa   = ($urandom_range(99) < 6);
      as_  = ($urandom_range(99) < 3);
      dis  = ($urandom_range(99) < 6);
      ok   = ($urandom_range(99) < 50);
      sec  = ($urandom_range(99) < 85);
      sens = ($urandom_range(99) < 8);
      drive(r, aa, as_, dis, ok, sec, sens);
    end

    wait_cnt = 0;
    while (q.size() > 0 && wait_cnt < 10) begin
      @(posedge clk);
      #2;
      wait_cnt++;
    end
    if (q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain pending=%0d required=0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
